// File: rtl/dram_pkg.sv
// Shared widths, state encoding and word/address types for the dram_model device.
package dram_pkg;

  localparam int unsigned ROW_BITS   = 11;
  localparam int unsigned COL_BITS   = 10;
  localparam int unsigned WORD_BITS  = 32;
  localparam int unsigned BYTE_LANES = 4;
  localparam int unsigned ADDR_BITS  = ROW_BITS + COL_BITS;

  typedef enum logic {IDLE, ACTIVE} dram_state_e;

  typedef logic [ROW_BITS-1:0]  row_t;
  typedef logic [COL_BITS-1:0]  col_t;
  typedef logic [WORD_BITS-1:0] word_t;
  typedef logic [ADDR_BITS-1:0] addr_t;

endpackage

// File: rtl/dram_read_pipe.sv
// Fixed-latency read return path: valid/data shift register, Q forced to zero when not valid.
module dram_read_pipe #(
  parameter int unsigned STAGES = 5,
  parameter int unsigned DATA_W = 32
) (
  input  logic              CK,
  input  logic              RST,
  input  logic              i_push,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_q
);

  logic [STAGES-1:0] r_vld_p;
  logic [DATA_W-1:0] r_data_p [STAGES];

  always_ff @(posedge CK) begin
    if (RST) begin
      r_vld_p <= '0;
    end else begin
      r_vld_p[0] <= i_push;
      for (int i = 1; i < int'(STAGES); i++) begin
        r_vld_p[i] <= r_vld_p[i-1];
      end
    end
  end

  always_ff @(posedge CK) begin
    r_data_p[0] <= i_data;
    for (int i = 1; i < int'(STAGES); i++) begin
      r_data_p[i] <= r_data_p[i-1];
    end
  end

  assign o_valid = r_vld_p[STAGES-1];
  assign o_q     = o_valid ? r_data_p[STAGES-1] : '0;

endmodule

// File: rtl/dram_model.sv
// DRAM device model: RAS/CAS decode, open-row state, four byte-lane arrays, fixed CAS latency.
// Optional simulation protocol checker enabled by defining DRAM_PROTOCOL_CHECK_EN.
module dram_model
  import dram_pkg::*;
#(
  parameter int unsigned CAS_LATENCY = 5
) (
  input  logic                  CK,
  input  logic                  RST,
  input  logic                  CSn,
  input  logic                  RASn,
  input  logic                  CASn,
  input  logic [BYTE_LANES-1:0] WEn,
  input  logic [ROW_BITS-1:0]   A,
  input  logic [WORD_BITS-1:0]  D,
  output word_t                 Q,
  output logic                  VALID
);

  localparam int unsigned DEPTH = 1 << ADDR_BITS;

  logic [7:0] Memory_byte0 [0:DEPTH-1];
  logic [7:0] Memory_byte1 [0:DEPTH-1];
  logic [7:0] Memory_byte2 [0:DEPTH-1];
  logic [7:0] Memory_byte3 [0:DEPTH-1];

  dram_state_e r_state;
  dram_state_e w_state_nxt;
  row_t        r_row;
  logic        w_act;
  logic        w_col;
  logic        w_wr;
  logic        w_rd;
  addr_t       w_idx;
  logic        r_rd_vld_p0;
  word_t       r_rd_data_p0;

  always_ff @(posedge CK) begin
    if (RST) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Illegal commands (CAS while idle, activate while active) simply fall through.
  always_comb begin
    w_state_nxt = r_state;
    w_act       = 1'b0;
    w_col       = 1'b0;
    case (r_state)
      IDLE: begin
        if (!CSn && !RASn && CASn) begin
          w_act       = 1'b1;
          w_state_nxt = ACTIVE;
        end
      end
      ACTIVE: begin
        if (!CSn) begin
          if (RASn)       w_state_nxt = IDLE;
          else if (!CASn) w_col       = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_idx = {r_row, A[COL_BITS-1:0]};
  assign w_wr  = w_col && (WEn != '1) && !RST;
  assign w_rd  = w_col && (WEn == '1);

  always_ff @(posedge CK) begin
    if (RST)        r_row <= '0;
    else if (w_act) r_row <= A;
  end

  always_ff @(posedge CK) if (w_wr && !WEn[0]) Memory_byte0[w_idx] <= D[7:0];
  always_ff @(posedge CK) if (w_wr && !WEn[1]) Memory_byte1[w_idx] <= D[15:8];
  always_ff @(posedge CK) if (w_wr && !WEn[2]) Memory_byte2[w_idx] <= D[23:16];
  always_ff @(posedge CK) if (w_wr && !WEn[3]) Memory_byte3[w_idx] <= D[31:24];

  // p0: word captured at the read CAS edge
  always_ff @(posedge CK) begin
    if (RST) r_rd_vld_p0 <= 1'b0;
    else     r_rd_vld_p0 <= w_rd;
  end

  always_ff @(posedge CK) begin
    if (w_rd) begin
      r_rd_data_p0 <= {Memory_byte3[w_idx], Memory_byte2[w_idx],
                       Memory_byte1[w_idx], Memory_byte0[w_idx]};
    end
  end

  // p1..pN: latency pipe, output lands CAS_LATENCY edges after the CAS edge
  dram_read_pipe #(
    .STAGES (CAS_LATENCY),
    .DATA_W (WORD_BITS)
  ) u_read_pipe (
    .CK      (CK),
    .RST     (RST),
    .i_push  (r_rd_vld_p0),
    .i_data  (r_rd_data_p0),
    .o_valid (VALID),
    .o_q     (Q)
  );

`ifdef DRAM_PROTOCOL_CHECK_EN
  always @(posedge CK) begin
    if (!RST) begin
      if ($isunknown({CSn, RASn, CASn, WEn})) begin
        $error("dram_model: X/Z on control pins");
      end else if (!CSn) begin
        if (r_state == IDLE && !CASn)
          $error("dram_model: CAS while no row is open");
        if (r_state == ACTIVE && !RASn && CASn)
          $error("dram_model: activate while a row is already open");
        if ((!RASn || !CASn) && $isunknown(A))
          $error("dram_model: X/Z on address during command");
      end
    end
  end
`else
  // No checking: illegal commands are dropped by the decode above.
`endif

endmodule

// File: tb/tb_dram_model.sv
// Directed plus randomized bench for dram_model against a queue-based behavioural model.
module tb_dram_model;

  localparam int CAS = 5;

  logic        CK = 1'b0;
  logic        RST = 1'b1;
  logic        CSn = 1'b1;
  logic        RASn = 1'b1;
  logic        CASn = 1'b1;
  logic [3:0]  WEn = 4'hF;
  logic [10:0] A = '0;
  logic [31:0] D = '0;
  logic [31:0] Q;
  logic        VALID;

  dram_model #(.CAS_LATENCY(CAS)) dut (
    .CK    (CK),
    .RST   (RST),
    .CSn   (CSn),
    .RASn  (RASn),
    .CASn  (CASn),
    .WEn   (WEn),
    .A     (A),
    .D     (D),
    .Q     (Q),
    .VALID (VALID)
  );

  always #5 CK = ~CK;

  typedef struct {
    int          due;
    logic [31:0] data;
  } rd_t;

  int          n_assert = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  logic [31:0] ref_mem [int];
  rd_t         exp_q [$];
  logic [31:0] got_q [$];
  int          got_cyc [$];
  bit          m_open = 1'b0;
  logic [10:0] m_row  = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int widx(input logic [10:0] row, input logic [9:0] col);
    return int'({row, col});
  endfunction

  task automatic preload(input int idx, input logic [31:0] v);
    dut.Memory_byte0[idx] = v[7:0];
    dut.Memory_byte1[idx] = v[15:8];
    dut.Memory_byte2[idx] = v[23:16];
    dut.Memory_byte3[idx] = v[31:24];
    ref_mem[idx] = v;
  endtask

  function automatic logic [31:0] peek(input int idx);
    return {dut.Memory_byte3[idx], dut.Memory_byte2[idx],
            dut.Memory_byte1[idx], dut.Memory_byte0[idx]};
  endfunction

  // Apply the command present on the pins to the model, as of edge number cyc+1.
  task automatic model_edge();
    int          idx;
    logic [31:0] w;
    if (RST) begin
      exp_q.delete();
      m_open = 1'b0;
      m_row  = '0;
    end else if (!CSn) begin
      if (!m_open) begin
        if (!RASn && CASn) begin
          m_open = 1'b1;
          m_row  = A;
        end
      end else if (RASn) begin
        m_open = 1'b0;
      end else if (!CASn) begin
        idx = widx(m_row, A[9:0]);
        if (WEn != 4'hF) begin
          w = ref_mem[idx];
          for (int b = 0; b < 4; b++)
            if (!WEn[b]) w[8*b +: 8] = D[8*b +: 8];
          ref_mem[idx] = w;
        end else begin
          exp_q.push_back('{due: cyc + 1 + CAS, data: ref_mem[idx]});
        end
      end
    end
  endtask

  task automatic step();
    bit          ev;
    logic [31:0] eq;
    model_edge();
    @(posedge CK);
    cyc++;
    #1;
    ev = 1'b0;
    eq = '0;
    if (exp_q.size() != 0 && exp_q[0].due == cyc) begin
      ev = 1'b1;
      eq = exp_q[0].data;
      void'(exp_q.pop_front());
    end
    chk("valid", {31'd0, VALID}, {31'd0, ev});
    chk("q", Q, eq);
    if (VALID) begin
      got_q.push_back(Q);
      got_cyc.push_back(cyc);
    end
  endtask

  task automatic cmd(input bit csn, input bit rasn, input bit casn,
                     input logic [3:0] wen, input logic [10:0] a, input logic [31:0] d);
    CSn = csn; RASn = rasn; CASn = casn; WEn = wen; A = a; D = d;
    step();
  endtask

  task automatic nop(input int n);
    for (int i = 0; i < n; i++) cmd(1'b1, 1'b1, 1'b1, 4'hF, '0, '0);
  endtask

  task automatic act(input logic [10:0] row);   cmd(1'b0, 1'b0, 1'b1, 4'hF, row, '0); endtask
  task automatic pre();                         cmd(1'b0, 1'b1, 1'b1, 4'hF, '0, '0); endtask
  task automatic rd(input logic [9:0] col);     cmd(1'b0, 1'b0, 1'b0, 4'hF, {1'b0, col}, '0); endtask
  task automatic wr(input logic [9:0] col, input logic [3:0] wen, input logic [31:0] d);
    cmd(1'b0, 1'b0, 1'b0, wen, {1'b0, col}, d);
  endtask

  logic [10:0] rows [5] = '{11'h000, 11'h003, 11'h005, 11'h100, 11'h200};

  initial begin
    int n0;
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 16; c++)
        preload(widx(rows[r], 10'(c)), $urandom);
    for (int c = 0; c < 4; c++) preload(widx(11'h200, 10'(c)), 32'(c));
    preload(widx(11'h003, 10'd9), 32'h3333_3333);
    preload(widx(11'h005, 10'd9), 32'h5555_5555);
    preload(widx(11'h007, 10'h055), 32'hA5A5_5A5A);

    // Reset held two cycles with random pins
    RST = 1'b1;
    for (int i = 0; i < 2; i++) begin
      CSn = 1'($urandom); RASn = 1'($urandom); CASn = 1'($urandom);
      WEn = 4'($urandom); A = 11'($urandom); D = $urandom;
      step();
    end
    chk("reset_valid", {31'd0, VALID}, 32'd0);
    chk("reset_q", Q, 32'd0);
    RST = 1'b0;
    nop(1);
    chk("reset_keeps_mem", peek(widx(11'h007, 10'h055)), 32'hA5A5_5A5A);

    // Full-word write then read
    act(11'h100);
    wr(10'h002, 4'h0, 32'hDEAD_BEEF);
    rd(10'h002);
    nop(4);
    chk("wr_rd_early", {31'd0, VALID}, 32'd0);
    nop(1);
    chk("wr_rd_valid", {31'd0, VALID}, 32'd1);
    chk("wr_rd_q", Q, 32'hDEAD_BEEF);
    nop(1);
    chk("wr_rd_pulse", {31'd0, VALID}, 32'd0);

    // Byte-lane write
    wr(10'h002, 4'b1010, 32'h1122_3344);
    rd(10'h002);
    nop(5);
    chk("byte_wr_q", Q, 32'hDE22_BE44);

    // Back-to-back reads
    pre();
    act(11'h200);
    got_q.delete(); got_cyc.delete();
    for (int c = 0; c < 4; c++) rd(10'(c));
    nop(6);
    chk("pipe_count", 32'(got_q.size()), 32'd4);
    for (int i = 0; i < 4 && i < got_q.size(); i++) begin
      chk("pipe_q", got_q[i], 32'(i));
      chk("pipe_consecutive", 32'(got_cyc[i]), 32'(got_cyc[0] + i));
    end

    // CAS while idle is ignored
    pre();
    n0 = got_q.size();
    cmd(1'b0, 1'b1, 1'b0, 4'h0, 11'h002, 32'h0BAD_0BAD);
    cmd(1'b0, 1'b1, 1'b0, 4'hF, 11'h002, '0);
    nop(7);
    chk("idle_cas_no_valid", 32'(got_q.size()), 32'(n0));
    chk("idle_cas_mem_a", peek(widx(11'h100, 10'h002)), 32'hDE22_BE44);
    chk("idle_cas_mem_b", peek(widx(11'h200, 10'h002)), 32'd2);

    // Activate while active keeps the open row
    act(11'h003);
    act(11'h005);
    rd(10'd9);
    nop(5);
    chk("dbl_act_q", Q, 32'h3333_3333);

    // Precharge just after a read CAS does not cancel it
    rd(10'd9);
    pre();
    nop(4);
    chk("pre_after_rd_valid", {31'd0, VALID}, 32'd1);
    chk("pre_after_rd_q", Q, 32'h3333_3333);

    // Reset two cycles after CAS discards the read
    act(11'h003);
    rd(10'd9);
    nop(1);
    n0 = got_q.size();
    RST = 1'b1;
    step();
    RST = 1'b0;
    nop(7);
    chk("rst_mid_read", 32'(got_q.size()), 32'(n0));

    // Randomized traffic over the preloaded region
    for (int i = 0; i < 600; i++) begin
      logic rs, cs;
      RST  = ($urandom_range(99) == 0);
      CSn  = ($urandom_range(4) == 0);
      rs   = 1'($urandom);
      cs   = ($urandom_range(2) != 0);
      RASn = rs; CASn = cs;
      WEn  = ($urandom_range(1) == 0) ? 4'hF : 4'($urandom);
      D    = $urandom;
      if (!rs && cs) A = rows[$urandom_range(4)];
      else           A = {1'($urandom), 6'd0, 4'($urandom)};
      step();
    end
    RST = 1'b0;
    nop(CAS + 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
